ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard over the shared open-drain PS2_CLK/PS2_DAT pair. Runs alongside the existing PS/2 receive path. The top level wraps its two drive-low enables into tri-states, so the receiver keeps seeing all traffic, including the 0xFA acknowledge byte the keyboard returns.

## Interface
- INHIBIT_CYCLES, 5000: cycles the clock line is held low before the request (100 µs at 50 MHz).
- START_TIMEOUT_CYCLES, 750000: maximum cycles from clock release to the first device falling edge (15 ms).
- XFER_TIMEOUT_CYCLES, 100000: maximum cycles from the first falling edge to ACK sampled (2 ms).
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- resetn  in  1  reset; asynchronous assert, active-low.
- command  in  8  byte to send; sampled only on an accepted send_command.
- send_command  in  1  single-cycle request; accepted only when busy=0.
- ps2_clk_in  in  1  raw PS2_CLK pin value (asynchronous).
- ps2_dat_in  in  1  raw PS2_DAT pin value (asynchronous).
- ps2_clk_oe  out  1  1 = pull PS2_CLK low; 0 = release.
- ps2_dat_oe  out  1  1 = pull PS2_DAT low; 0 = release.
- busy  out  1  high from the cycle after acceptance until return to IDLE.
- command_was_sent  out  1  one-cycle pulse on successful completion.
- error_communication_timed_out  out  1  one-cycle pulse on timeout or NACK.

## Operation
- Reset values: all outputs 0, state IDLE, both lines released. Reset mid-transfer releases both lines immediately and does not pulse either status output.
- Synchronise ps2_clk_in and ps2_dat_in through 2 flops each, then a delay register. A device falling edge is prev=1 and cur=0.
- Latch on acceptance: shift register = {odd parity = ~^command, command}. Bit counter = 0.
- States and transitions:
  - IDLE: accepted send_command goes to INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1, dat_oe=1 for 1 cycle, then WAIT_START.
  - WAIT_START: clk_oe=0, dat_oe=1 (start bit 0). On a falling edge, drive data bit 0 and go to DATA.
  - DATA: on each falling edge, drive the next bit, LSB first, then parity. dat_oe = ~bit.
  - STOP: the falling edge after parity is driven sets dat_oe=0 (stop bit 1).
  - ACK: on the next falling edge, sample the synchronised data, then go to DONE or ERR.
  - DONE: pulse command_was_sent, return to IDLE.
  - ERR: pulse error, release both lines, return to IDLE.
- Timeouts:
  - The start counter runs in WAIT_START.
  - The transfer counter runs from the DATA entry through ACK.
  - Either counter reaching its limit goes to ERR, even if a falling edge arrives on that cycle.
- send_command while busy=1 is ignored and not queued. send_command in the same cycle as DONE/ERR is also ignored.
- Glitches on the pins between falling edges have no effect; only synchronised falling edges advance the FSM.

## Timing
- send_command at cycle t: busy=1 and clk_oe=1 at t+1. clk_oe falls at t+1+INHIBIT_CYCLES+1.
- Pin falling edge to dat_oe update: at most 4 CLOCK_50 cycles (2 sync, 1 edge detect, 1 output register).
- Completion pulse at the cycle after the ACK edge is detected; busy drops in the same cycle as the pulse.
- Total device edges consumed per command: 11 (data 8, parity, stop, ack).

## Configuration
- PS2_TX_ACK_CHECK_EN defined:
  - In ACK, synchronised data = 0 means DONE.
  - Data = 1 (NACK) means ERR and an error pulse.
- Not defined:
  - The ACK-slot falling edge always goes to DONE; the data value is ignored.
  - The timeout behaviour is unchanged.

## Test plan
- command=0xED, device model clocks at 12.5 kHz and ACKs -> line shows bits 1,0,1,1,0,1,1,1, parity 1, stop 1; one command_was_sent pulse; busy=0.
- command=0x00 -> parity bit 1; command=0x01 -> parity bit 0; both complete.
- Device never clocks after release -> error pulse exactly START_TIMEOUT_CYCLES cycles after clk_oe falls; both oe=0.
- Device stops after 5 edges -> error pulse at XFER_TIMEOUT_CYCLES; run with and without PS2_TX_ACK_CHECK_EN; NACK in the ACK slot -> error only with the macro defined.
- send_command pulsed again mid-transfer -> ignored; exactly one byte is sent.
- resetn low during DATA -> both oe=0 asynchronously, no pulses; the next send of 0xFF then completes normally.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte over open-drain PS2_CLK/PS2_DAT.
// Define PS2_TX_ACK_CHECK_EN to treat a high data line in the ACK slot as a NACK error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES       = 5000,
    parameter int unsigned START_TIMEOUT_CYCLES = 750000,
    parameter int unsigned XFER_TIMEOUT_CYCLES  = 100000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] command,
    input  logic       send_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_communication_timed_out
);

    localparam int unsigned MAX_A   = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ?
                                      INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
    localparam int unsigned TMR_MAX = (MAX_A > XFER_TIMEOUT_CYCLES) ? MAX_A : XFER_TIMEOUT_CYCLES;
    localparam int unsigned TW      = $clog2(TMR_MAX + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] XFER_LAST    = TW'(XFER_TIMEOUT_CYCLES - 1);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_INHIBIT    = 4'd1;
    localparam logic [3:0] ST_REQ        = 4'd2;
    localparam logic [3:0] ST_WAIT_START = 4'd3;
    localparam logic [3:0] ST_DATA       = 4'd4;
    localparam logic [3:0] ST_STOP       = 4'd5;
    localparam logic [3:0] ST_ACK        = 4'd6;
    localparam logic [3:0] ST_DONE       = 4'd7;
    localparam logic [3:0] ST_ERR        = 4'd8;

    logic [1:0]    clk_sync_q;
    logic          clk_prev_q;
    logic [1:0]    dat_sync_q;
    logic          clk_fall;

    logic [3:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [8:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          dat_oe_d;
    logic          timed_out;

    // Pins idle high, so the synchronisers reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clk_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
            clk_prev_q <= clk_sync_q[1];
            dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
        end
    end

    assign clk_fall = clk_prev_q & ~clk_sync_q[1];

    // One shared timer: each phase restarts it on entry, and the phases never overlap.
    always_comb begin
        timed_out = 1'b0;
        if (state_q == ST_WAIT_START) begin
            timed_out = (tmr_q == START_LAST);
        end else if (state_q == ST_DATA || state_q == ST_STOP || state_q == ST_ACK) begin
            timed_out = (tmr_q == XFER_LAST);
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        dat_oe_d  = ps2_dat_oe;

        if (timed_out) begin
            state_d  = ST_ERR;
            dat_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    dat_oe_d = 1'b0;
                    if (send_command) begin
                        state_d   = ST_INHIBIT;
                        tmr_d     = '0;
                        shift_d   = {~^command, command};
                        bit_cnt_d = '0;
                    end
                end
                ST_INHIBIT: begin
                    if (tmr_q == INHIBIT_LAST) begin
                        state_d  = ST_REQ;
                        tmr_d    = '0;
                        dat_oe_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_REQ: begin
                    state_d  = ST_WAIT_START;
                    tmr_d    = '0;
                    dat_oe_d = 1'b1;
                end
                ST_WAIT_START: begin
                    tmr_d = tmr_q + 1'b1;
                    if (clk_fall) begin
                        state_d   = ST_DATA;
                        tmr_d     = '0;
                        dat_oe_d  = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    tmr_d = tmr_q + 1'b1;
                    if (clk_fall) begin
                        dat_oe_d  = ~shift_q[0];
                        shift_d   = {1'b0, shift_q[8:1]};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        // Eighth edge in DATA puts the parity bit on the line.
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    tmr_d = tmr_q + 1'b1;
                    if (clk_fall) begin
                        state_d  = ST_ACK;
                        dat_oe_d = 1'b0;
                    end
                end
                ST_ACK: begin
                    tmr_d = tmr_q + 1'b1;
                    if (clk_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                        state_d = dat_sync_q[1] ? ST_ERR : ST_DONE;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    state_d  = ST_IDLE;
                    dat_oe_d = 1'b0;
                end
                ST_ERR: begin
                    state_d  = ST_IDLE;
                    dat_oe_d = 1'b0;
                end
                default: begin
                    state_d  = ST_IDLE;
                    dat_oe_d = 1'b0;
                end
            endcase
        end
    end

`ifndef PS2_TX_ACK_CHECK_EN
    logic unused_ack_dat;
    assign unused_ack_dat = dat_sync_q[1];
`endif

    // Outputs are registered from the next state so the pin enables never glitch.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q                       <= ST_IDLE;
            tmr_q                         <= '0;
            shift_q                       <= '0;
            bit_cnt_q                     <= '0;
            ps2_clk_oe                    <= 1'b0;
            ps2_dat_oe                    <= 1'b0;
            busy                          <= 1'b0;
            command_was_sent              <= 1'b0;
            error_communication_timed_out <= 1'b0;
        end else begin
            state_q                       <= state_d;
            tmr_q                         <= tmr_d;
            shift_q                       <= shift_d;
            bit_cnt_q                     <= bit_cnt_d;
            ps2_clk_oe                    <= (state_d == ST_INHIBIT) || (state_d == ST_REQ);
            ps2_dat_oe                    <= dat_oe_d;
            busy                          <= (state_d != ST_IDLE) && (state_d != ST_DONE) &&
                                             (state_d != ST_ERR);
            command_was_sent              <= (state_d == ST_DONE);
            error_communication_timed_out <= (state_d == ST_ERR);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model with a bit/outcome scoreboard.
// Build with PS2_TX_ACK_CHECK_EN to exercise the NACK path.
module tb_ps2_host_tx;

    localparam int unsigned INH   = 50;
    localparam int unsigned START = 600;
    localparam int unsigned XFER  = 1000;
    localparam int          HALF  = 20;

    logic       CLOCK_50 = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] command = 8'h00;
    logic       send_command = 1'b0;
    logic       ps2_clk_in, ps2_dat_in;
    logic       ps2_clk_oe, ps2_dat_oe;
    logic       busy, command_was_sent, error_communication_timed_out;

    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;

    assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES      (INH),
        .START_TIMEOUT_CYCLES(START),
        .XFER_TIMEOUT_CYCLES (XFER)
    ) dut (
        .CLOCK_50                     (CLOCK_50),
        .resetn                       (resetn),
        .command                      (command),
        .send_command                 (send_command),
        .ps2_clk_in                   (ps2_clk_in),
        .ps2_dat_in                   (ps2_dat_in),
        .ps2_clk_oe                   (ps2_clk_oe),
        .ps2_dat_oe                   (ps2_dat_oe),
        .busy                         (busy),
        .command_was_sent             (command_was_sent),
        .error_communication_timed_out(error_communication_timed_out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_rel = 0;
    int t_dat = 0;
    logic armed = 1'b0;
    logic clk_oe_prev = 1'b0;
    logic dat_oe_prev = 1'b0;
    logic [1:0] exp_out;

    logic       bit_q[$];
    logic [1:0] out_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Release-time bookkeeping for the timing checks.
    always @(negedge CLOCK_50) begin
        if (clk_oe_prev && !ps2_clk_oe) begin
            t_rel <= cyc;
            armed <= 1'b1;
        end else if (armed && dat_oe_prev && !ps2_dat_oe) begin
            t_dat <= cyc;
            armed <= 1'b0;
        end
        clk_oe_prev <= ps2_clk_oe;
        dat_oe_prev <= ps2_dat_oe;
    end

    // Outcome scoreboard: {error, sent}.
    always @(negedge CLOCK_50) begin
        if (command_was_sent || error_communication_timed_out) begin
            if (out_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, error_communication_timed_out, command_was_sent},
                      32'd0);
            end else begin
                exp_out = out_q.pop_front();
                check("outcome", {30'd0, error_communication_timed_out, command_was_sent},
                      {30'd0, exp_out});
            end
        end
    end

    task automatic send(input logic [7:0] cmd, output int t_send);
        logic [10:0] bits;
        bits = {1'b1, ~^cmd, cmd, 1'b0};
        for (int i = 0; i < 11; i++) bit_q.push_back(bits[i]);
        t_send = cyc;
        command = cmd;
        send_command = 1'b1;
        @(negedge CLOCK_50);
        send_command = 1'b0;
        command = ~cmd;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("clk_oe_after_accept", {31'd0, ps2_clk_oe}, 32'd1);
    endtask

    task automatic dev_run(input int n_edges, input bit ack);
        int   n;
        logic smp;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1 && busy)) begin
            @(negedge CLOCK_50);
            n++;
            if (n > 5000) begin
                check("rts_wait", n, 5000);
                return;
            end
        end
        for (int e = 1; e <= n_edges; e++) begin
            repeat (HALF) @(negedge CLOCK_50);
            smp = ps2_dat_in;
            if (bit_q.size() == 0) check("line_bit_extra", {31'd0, smp}, 32'd2);
            else check($sformatf("line_bit%0d", e - 1), {31'd0, smp}, {31'd0, bit_q.pop_front()});
            if (e == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (4) @(negedge CLOCK_50);
            end
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge CLOCK_50);
            dev_clk_low = 1'b0;
            dev_dat_low = 1'b0;
        end
        repeat (HALF) @(negedge CLOCK_50);
    endtask

    task automatic wait_pulse(input int limit, input bit resend, output int t);
        int n;
        n = 0;
        t = -1;
        forever begin
            @(negedge CLOCK_50);
            n++;
            if (command_was_sent || error_communication_timed_out) break;
            if (n > limit) begin
                check("pulse_timeout", n, limit);
                return;
            end
        end
        t = cyc;
        if (resend) begin
            command = 8'hAA;
            send_command = 1'b1;
            @(negedge CLOCK_50);
            send_command = 1'b0;
        end
    endtask

    task automatic settle_idle(input bit full);
        repeat (60) @(negedge CLOCK_50);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("clk_oe_idle", {31'd0, ps2_clk_oe}, 32'd0);
        if (full) check("bits_left", bit_q.size(), 0);
        bit_q.delete();
    endtask

    task automatic full_xfer(input logic [7:0] cmd, input bit ack, input logic [1:0] outcome,
                             input bit resend);
        int ts, tp;
        send(cmd, ts);
        out_q.push_back(outcome);
        fork
            dev_run(11, ack);
            wait_pulse(3000, resend, tp);
        join
        check("inhibit_len", t_rel - ts, INH + 2);
        settle_idle(1'b1);
    endtask

    initial begin
        int ts, tp;
        repeat (3) @(negedge CLOCK_50);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        check("rst_sent", {31'd0, command_was_sent}, 32'd0);
        check("rst_err", {31'd0, error_communication_timed_out}, 32'd0);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        full_xfer(8'hED, 1'b1, 2'b01, 1'b0);
        full_xfer(8'h00, 1'b1, 2'b01, 1'b0);
        // Request in the DONE cycle must be dropped.
        full_xfer(8'h01, 1'b1, 2'b01, 1'b1);

        // Device never clocks.
        send(8'h5A, ts);
        out_q.push_back(2'b10);
        wait_pulse(3000, 1'b0, tp);
        check("start_timeout", tp - t_rel, START);
        check("err_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("err_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        settle_idle(1'b0);

        // Device stops after five edges.
        send(8'hED, ts);
        out_q.push_back(2'b10);
        fork
            dev_run(5, 1'b1);
            wait_pulse(3000, 1'b0, tp);
        join
        check("xfer_timeout", tp - t_dat, XFER);
        settle_idle(1'b0);

        // NACK in the ACK slot.
`ifdef PS2_TX_ACK_CHECK_EN
        full_xfer(8'hF4, 1'b0, 2'b10, 1'b0);
`else
        full_xfer(8'hF4, 1'b0, 2'b01, 1'b0);
`endif

        // Second request mid-transfer is ignored.
        send(8'h3C, ts);
        out_q.push_back(2'b01);
        fork
            dev_run(11, 1'b1);
            wait_pulse(3000, 1'b0, tp);
            begin
                repeat (150) @(negedge CLOCK_50);
                command = 8'h12;
                send_command = 1'b1;
                @(negedge CLOCK_50);
                send_command = 1'b0;
            end
        join
        settle_idle(1'b1);

        // Reset during DATA.
        send(8'hED, ts);
        dev_run(2, 1'b1);
        check("pre_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd1);
        #3 resetn = 1'b0;
        #1;
        check("async_rst_dat_oe", {31'd0, ps2_dat_oe}, 32'd0);
        check("async_rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge CLOCK_50);
        resetn = 1'b1;
        bit_q.delete();
        repeat (3) @(negedge CLOCK_50);
        full_xfer(8'hFF, 1'b1, 2'b01, 1'b0);

        check("outcomes_left", out_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
